// File: rtl/di_term_arbiter.sv
// Terminal response mux and stall watchdog between HostInterface and the di_* terminals.
// A terminal that stalls too long is overridden so the FX2 transfer can still complete.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | raw terminal signals pass through; wd_cnt counts stalled cycles
// ST_FORCED | stalled ready is forced high (plus ERR_DATA on reads) until both modes drop
module di_term_arbiter #(
  parameter int                        NUM_TERMS     = 4,
  parameter logic [16*NUM_TERMS-1:0]   TERM_ADDRS    = {16'h3, 16'h2, 16'h1, 16'h0},
  parameter int                        TIMEOUT       = 1024,
  parameter logic [15:0]               ERR_DATA      = 16'hDEAD,
  parameter logic [15:0]               UNMAPPED_DATA = 16'h0000
) (
  input  logic                        ifclk,
  input  logic                        reset,
  input  logic [15:0]                 di_term_addr,
  input  logic                        di_read_mode,
  input  logic                        di_write_mode,
  input  logic                        di_read_req,
  input  logic                        di_read,
  input  logic                        di_write,
  input  logic [16*NUM_TERMS-1:0]     term_datao,
  input  logic [NUM_TERMS-1:0]        term_read_rdy,
  input  logic [NUM_TERMS-1:0]        term_write_rdy,
  output logic [15:0]                 di_reg_datao,
  output logic                        di_read_rdy,
  output logic                        di_write_rdy,
  input  logic                        clear_status,
  output logic                        timeout_flag,
  output logic [15:0]                 timeout_term,
  output logic [7:0]                  timeout_count,
  output logic                        forced
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_FORCED = 1'b1;
  localparam logic [15:0] WD_LIMIT  = 16'(TIMEOUT - 1);

  logic [0:0]  state;
  logic [15:0] wd_cnt;
  logic        force_rd;
  logic        sel_hit;
  logic        raw_read_rdy;
  logic        raw_write_rdy;
  logic [15:0] raw_datao;
  logic        stall;
  logic        to_event;
  logic        unused_strobes;

  // The host strobes reach the terminals directly; this block only watches the modes.
  assign unused_strobes = ^{di_read_req, di_read, di_write};

  // Descending scan so the lowest matching slot is the last assignment and wins.
  always_comb begin
    sel_hit       = 1'b0;
    raw_read_rdy  = 1'b1;
    raw_write_rdy = 1'b1;
    raw_datao     = UNMAPPED_DATA;
    for (int i = NUM_TERMS - 1; i >= 0; i--) begin
      if (di_term_addr == TERM_ADDRS[16*i +: 16]) begin
        sel_hit       = 1'b1;
        raw_read_rdy  = term_read_rdy[i];
        raw_write_rdy = term_write_rdy[i];
        raw_datao     = term_datao[16*i +: 16];
      end
    end
  end

  assign stall    = sel_hit && ((di_read_mode && !raw_read_rdy) ||
                                (di_write_mode && !raw_write_rdy));
  assign to_event = (state == ST_IDLE) && stall && (wd_cnt == WD_LIMIT);
  assign forced   = (state == ST_FORCED);

  always_comb begin
    di_read_rdy  = raw_read_rdy;
    di_write_rdy = raw_write_rdy;
    di_reg_datao = raw_datao;
    if (forced && force_rd) begin
      di_read_rdy  = 1'b1;
      di_reg_datao = ERR_DATA;
    end else if (forced) begin
      di_write_rdy = 1'b1;
    end
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wd_cnt        <= 16'd0;
      force_rd      <= 1'b0;
      timeout_flag  <= 1'b0;
      timeout_term  <= 16'd0;
      timeout_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (to_event) begin
            state    <= ST_FORCED;
            wd_cnt   <= 16'd0;
            force_rd <= di_read_mode;
          end else if (stall) begin
            wd_cnt <= wd_cnt + 16'd1;
          end else begin
            wd_cnt <= 16'd0;
          end
        end
        default: begin
          wd_cnt <= 16'd0;
          if (!di_read_mode && !di_write_mode) state <= ST_IDLE;
        end
      endcase

      if (clear_status) begin
        timeout_flag  <= 1'b0;
        timeout_term  <= 16'd0;
        timeout_count <= 8'd0;
      end
      // A timeout in the same cycle as a clear overrides it and counts as the first event.
      if (to_event) begin
        timeout_flag  <= 1'b1;
        timeout_term  <= di_term_addr;
        if (clear_status)               timeout_count <= 8'd1;
        else if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_di_term_arbiter.sv
// Directed self-checking bench for di_term_arbiter with TIMEOUT=16 and terminals at 0..3.
module tb_di_term_arbiter;
  logic        ifclk = 1'b0;
  logic        reset;
  logic [15:0] di_term_addr;
  logic        di_read_mode, di_write_mode;
  logic        di_read_req, di_read, di_write;
  logic [63:0] term_datao;
  logic [3:0]  term_read_rdy, term_write_rdy;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy, di_write_rdy;
  logic        clear_status;
  logic        timeout_flag;
  logic [15:0] timeout_term;
  logic [7:0]  timeout_count;
  logic        forced;

  int errors = 0;
  int checks = 0;

  di_term_arbiter #(
    .NUM_TERMS(4), .TERM_ADDRS({16'h3, 16'h2, 16'h1, 16'h0}), .TIMEOUT(16),
    .ERR_DATA(16'hDEAD), .UNMAPPED_DATA(16'h0000)
  ) dut (
    .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr),
    .di_read_mode(di_read_mode), .di_write_mode(di_write_mode),
    .di_read_req(di_read_req), .di_read(di_read), .di_write(di_write),
    .term_datao(term_datao), .term_read_rdy(term_read_rdy), .term_write_rdy(term_write_rdy),
    .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
    .clear_status(clear_status), .timeout_flag(timeout_flag), .timeout_term(timeout_term),
    .timeout_count(timeout_count), .forced(forced)
  );

  always #5 ifclk = ~ifclk;

  // Advance to just after the next rising edge; inputs set afterwards apply to that cycle.
  task automatic step();
    @(posedge ifclk);
    #1;
  endtask

  task automatic settle();
    #1;
    checks++;
  endtask

  task automatic test_reset();
    reset = 1'b1; di_term_addr = 16'h0; di_read_mode = 0; di_write_mode = 0;
    di_read_req = 0; di_read = 0; di_write = 0; clear_status = 0;
    term_datao = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    term_read_rdy = 4'hF; term_write_rdy = 4'hF;
    step(); step();
    reset = 1'b0;
    step();
    settle();
    if (forced !== 1'b0 || timeout_flag !== 1'b0 || timeout_count !== 8'd0 || timeout_term !== 16'd0) begin
      errors++; $display("FAIL reset_status: forced=%b flag=%b count=%0d term=%h, expected 0 0 0 0",
                         forced, timeout_flag, timeout_count, timeout_term);
    end
    settle();
    if (di_reg_datao !== 16'hA000 || di_read_rdy !== 1'b1 || di_write_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_mirror: data=%h rrdy=%b wrdy=%b, expected A000 1 1",
                         di_reg_datao, di_read_rdy, di_write_rdy);
    end
    term_read_rdy[0] = 1'b0; term_write_rdy[0] = 1'b0;
    settle();
    if (di_read_rdy !== 1'b0 || di_write_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_mirror_low: rrdy=%b wrdy=%b, expected 0 0", di_read_rdy, di_write_rdy);
    end
    term_read_rdy = 4'hF; term_write_rdy = 4'hF;
  endtask

  task automatic test_short_stall();
    step();
    di_term_addr = 16'h2; di_read_mode = 1'b1; term_read_rdy[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (di_read_rdy !== 1'b0 || di_reg_datao !== 16'hA002 || forced !== 1'b0) begin
        errors++; $display("FAIL short_stall_pass k=%0d: rrdy=%b data=%h forced=%b, expected 0 A002 0",
                           k, di_read_rdy, di_reg_datao, forced);
      end
      step();
    end
    term_read_rdy[2] = 1'b1;
    settle();
    if (di_read_rdy !== 1'b1) begin
      errors++; $display("FAIL short_stall_release: rrdy=%b, expected 1", di_read_rdy);
    end
    // 15 stalled, 1 ready, 15 stalled: the counter must restart, so no timeout.
    step(); term_read_rdy[2] = 1'b0;
    for (int k = 0; k < 15; k++) step();
    term_read_rdy[2] = 1'b1;
    step(); term_read_rdy[2] = 1'b0;
    for (int k = 0; k < 15; k++) step();
    settle();
    if (forced !== 1'b0 || timeout_count !== 8'd0 || timeout_flag !== 1'b0) begin
      errors++; $display("FAIL consecutive_restart: forced=%b count=%0d flag=%b, expected 0 0 0",
                         forced, timeout_count, timeout_flag);
    end
    di_read_mode = 1'b0; term_read_rdy[2] = 1'b1;
  endtask

  task automatic test_read_timeout();
    step();
    di_term_addr = 16'h1; di_read_mode = 1'b1; term_read_rdy[1] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        settle();
        if (forced !== 1'b0 || di_read_rdy !== 1'b0) begin
          errors++; $display("FAIL read_timeout_early: forced=%b rrdy=%b at cycle 15, expected 0 0",
                             forced, di_read_rdy);
        end
      end
    end
    settle();
    if (forced !== 1'b1 || di_read_rdy !== 1'b1 || di_reg_datao !== 16'hDEAD) begin
      errors++; $display("FAIL read_timeout_force: forced=%b rrdy=%b data=%h, expected 1 1 DEAD",
                         forced, di_read_rdy, di_reg_datao);
    end
    settle();
    if (timeout_flag !== 1'b1 || timeout_term !== 16'h1 || timeout_count !== 8'd1) begin
      errors++; $display("FAIL read_timeout_status: flag=%b term=%h count=%0d, expected 1 0001 1",
                         timeout_flag, timeout_term, timeout_count);
    end
    di_read_mode = 1'b0;
    step();
    settle();
    if (forced !== 1'b0 || di_reg_datao !== 16'hA001) begin
      errors++; $display("FAIL read_timeout_exit: forced=%b data=%h, expected 0 A001", forced, di_reg_datao);
    end
    term_read_rdy[1] = 1'b1;
  endtask

  task automatic test_unmapped();
    step();
    di_term_addr = 16'h0042; di_read_mode = 1'b1; di_write_mode = 1'b1;
    term_read_rdy = 4'h0; term_write_rdy = 4'h0;
    settle();
    if (di_read_rdy !== 1'b1 || di_write_rdy !== 1'b1 || di_reg_datao !== 16'h0000) begin
      errors++; $display("FAIL unmapped_resp: rrdy=%b wrdy=%b data=%h, expected 1 1 0000",
                         di_read_rdy, di_write_rdy, di_reg_datao);
    end
    for (int k = 0; k < 20; k++) step();
    settle();
    if (forced !== 1'b0 || timeout_count !== 8'd1) begin
      errors++; $display("FAIL unmapped_nocount: forced=%b count=%0d, expected 0 1", forced, timeout_count);
    end
    di_read_mode = 1'b0; di_write_mode = 1'b0;
    term_read_rdy = 4'hF; term_write_rdy = 4'hF;
  endtask

  task automatic test_write_timeout();
    step();
    di_term_addr = 16'h3; di_write_mode = 1'b1;
    term_write_rdy[3] = 1'b0; term_read_rdy[3] = 1'b0;
    for (int k = 1; k <= 15; k++) step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    settle();
    if (forced !== 1'b1 || di_write_rdy !== 1'b1 || di_read_rdy !== 1'b0 || di_reg_datao !== 16'hA003) begin
      errors++; $display("FAIL write_timeout_force: forced=%b wrdy=%b rrdy=%b data=%h, expected 1 1 0 A003",
                         forced, di_write_rdy, di_read_rdy, di_reg_datao);
    end
    settle();
    if (timeout_flag !== 1'b1 || timeout_count !== 8'd1 || timeout_term !== 16'h3) begin
      errors++; $display("FAIL clear_vs_timeout: flag=%b count=%0d term=%h, expected 1 1 0003",
                         timeout_flag, timeout_count, timeout_term);
    end
    di_term_addr = 16'h2;
    step();
    settle();
    if (forced !== 1'b1) begin
      errors++; $display("FAIL addr_change_forced: forced=%b, expected 1", forced);
    end
    di_write_mode = 1'b0;
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    settle();
    if (forced !== 1'b0 || timeout_flag !== 1'b0 || timeout_count !== 8'd0 || timeout_term !== 16'd0) begin
      errors++; $display("FAIL clear_alone: forced=%b flag=%b count=%0d term=%h, expected 0 0 0 0",
                         forced, timeout_flag, timeout_count, timeout_term);
    end
    term_write_rdy = 4'hF; term_read_rdy = 4'hF;
  endtask

  task automatic test_saturate_and_reset();
    di_term_addr = 16'h1;
    for (int n = 1; n <= 300; n++) begin
      di_read_mode = 1'b1; term_read_rdy[1] = 1'b0;
      for (int k = 0; k < 16; k++) step();
      if (n == 254) begin
        settle();
        if (timeout_count !== 8'd254) begin
          errors++; $display("FAIL count_254: count=%0d, expected 254", timeout_count);
        end
      end
      di_read_mode = 1'b0;
      step();
    end
    settle();
    if (timeout_count !== 8'd255 || timeout_flag !== 1'b1) begin
      errors++; $display("FAIL count_saturate: count=%0d flag=%b, expected 255 1", timeout_count, timeout_flag);
    end
    di_read_mode = 1'b1;
    for (int k = 0; k < 16; k++) step();
    settle();
    if (forced !== 1'b1) begin
      errors++; $display("FAIL pre_reset_forced: forced=%b, expected 1", forced);
    end
    reset = 1'b1;
    step();
    settle();
    if (forced !== 1'b0 || timeout_flag !== 1'b0 || timeout_count !== 8'd0 || timeout_term !== 16'd0) begin
      errors++; $display("FAIL reset_midtxn: forced=%b flag=%b count=%0d term=%h, expected 0 0 0 0",
                         forced, timeout_flag, timeout_count, timeout_term);
    end
    settle();
    if (di_read_rdy !== 1'b0 || di_reg_datao !== 16'hA001) begin
      errors++; $display("FAIL reset_raw: rrdy=%b data=%h, expected 0 A001", di_read_rdy, di_reg_datao);
    end
    reset = 1'b0; di_read_mode = 1'b0; term_read_rdy = 4'hF;
    step();
  endtask

  initial begin
    test_reset();
    test_short_stall();
    test_read_timeout();
    test_unmapped();
    test_write_timeout();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
